// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit: per-register result countdowns decide stall,
// forward tap or register-file read at issue, and guard WAW order and the single write port.
module hazard_scoreboard #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned RAW       = 5,
  parameter int unsigned MAX_LAT   = 8,
  parameter int unsigned FWD_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic                               id_flush,
  input  logic                               pipe_hold,
  input  logic [RAW-1:0]                     id_rs,
  input  logic                               id_rs_used,
  input  logic [RAW-1:0]                     id_rt,
  input  logic                               id_rt_used,
  input  logic                               id_wr_en,
  input  logic [RAW-1:0]                     id_wr_reg,
  input  logic [$clog2(MAX_LAT+1)-1:0]       id_wr_lat,
  output logic                               stall,
  output logic                               issue,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_rs_sel,
  output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_rt_sel
);

  localparam int unsigned CW    = $clog2(MAX_LAT + FWD_DEPTH + 2);
  localparam int unsigned LW    = $clog2(MAX_LAT + 1);
  localparam int unsigned SW    = $clog2(FWD_DEPTH + 1);
  localparam int unsigned NSLOT = MAX_LAT + FWD_DEPTH + 1;

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FWD  = CW'(FWD_DEPTH);
  localparam logic [CW-1:0] C_FWD1 = CW'(FWD_DEPTH + 1);
  localparam logic [CW-1:0] C_FWD2 = CW'(FWD_DEPTH + 2);
  localparam logic [CW-1:0] C_MAX  = CW'(MAX_LAT);
  localparam logic [LW-1:0] L_MAX  = LW'(MAX_LAT);

  logic [CW-1:0]    cnt_q [NREG];
  logic [CW-1:0]    cnt_d [NREG];
  logic [NSLOT:1]   slot_q;
  logic [NSLOT:1]   slot_d;

  logic [CW-1:0]    lat_c;
  logic [CW-1:0]    tgt_c;
  logic [CW-1:0]    rs_cnt;
  logic [CW-1:0]    rt_cnt;
  logic [CW-1:0]    wr_cnt;
  logic             wr_act;
  logic             rs_haz;
  logic             rt_haz;
  logic             waw_haz;
  logic             str_haz;
  logic             live;

  // cnt in 2..FWD_DEPTH+1 maps to a forward tap; 0/1 means the register file already holds it.
  function automatic logic [SW-1:0] sel_of(input logic [CW-1:0] c);
    if (c <= C_ONE || c > C_FWD1) return '0;
    return SW'(C_FWD2 - c);
  endfunction

  always_comb begin
    lat_c = CW'(id_wr_lat);
    if (id_wr_lat == '0)        lat_c = C_ONE;
    else if (id_wr_lat > L_MAX) lat_c = C_MAX;
    tgt_c   = lat_c + C_FWD;
    wr_act  = id_wr_en && (id_wr_reg != '0);
    rs_cnt  = cnt_q[id_rs];
    rt_cnt  = cnt_q[id_rt];
    wr_cnt  = cnt_q[id_wr_reg];
    rs_haz  = id_rs_used && (id_rs != '0) && (rs_cnt > C_FWD1);
    rt_haz  = id_rt_used && (id_rt != '0) && (rt_cnt > C_FWD1);
    waw_haz = wr_act && (wr_cnt > tgt_c + C_ONE);
    str_haz = wr_act && slot_q[tgt_c + C_ONE];
    // Reset gates the outputs so they read as idle while state is being cleared.
    live    = id_valid && !id_flush && !reset;
    stall   = live && (rs_haz || rt_haz || waw_haz || str_haz);
    issue   = live && !(rs_haz || rt_haz || waw_haz || str_haz) && !pipe_hold;
    fwd_rs_sel = sel_of(rs_cnt);
    fwd_rt_sel = sel_of(rt_cnt);
  end

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!pipe_hold) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - C_ONE;
      end
      slot_d = {1'b0, slot_q[NSLOT:2]};
      if (issue && wr_act) begin
        cnt_d[id_wr_reg] = tgt_c;
        slot_d[tgt_c]    = 1'b1;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '{default: '0};
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random issue traffic,
// checked against a model that tracks absolute completion times per register.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       id_valid, id_flush, pipe_hold;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       id_rs_used, id_rt_used, id_wr_en;
  logic [3:0] id_wr_lat;
  logic       stall, issue;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // model: absolute completion time per register, and all pending write-back times
  int unsigned eta [32];
  int unsigned wbq [$];
  int unsigned now = 100;

  hazard_scoreboard #(.NREG(32), .RAW(5), .MAX_LAT(8), .FWD_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_flush(id_flush), .pipe_hold(pipe_hold),
    .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_wr_lat(id_wr_lat),
    .stall(stall), .issue(issue), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned mcnt(input int unsigned r);
    if (r == 0) return 0;
    return (eta[r] > now) ? eta[r] - now : 0;
  endfunction

  function automatic bit slot_busy(input int unsigned k);
    foreach (wbq[i]) if (wbq[i] == now + k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned msel(input int unsigned c);
    if (c <= 1 || c > 3) return 0;
    return 4 - c;
  endfunction

  task automatic model_reset();
    foreach (eta[i]) eta[i] = 0;
    wbq.delete();
  endtask

  task automatic setid(input bit v, input bit f, input bit h,
                       input logic [4:0] rs, input bit rsu,
                       input logic [4:0] rt, input bit rtu,
                       input bit we, input logic [4:0] wr, input logic [3:0] lat);
    id_valid = v; id_flush = f; pipe_hold = h;
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_wr_en = we; id_wr_reg = wr; id_wr_lat = lat;
  endtask

  task automatic idle();
    setid(0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 4'd0);
  endtask

  task automatic wr_op(input logic [4:0] r, input logic [3:0] lat);
    setid(1, 0, 0, 5'd0, 0, 5'd0, 0, 1, r, lat);
  endtask

  task automatic rd_rs(input logic [4:0] r, input bit hold);
    setid(1, 0, hold, r, 1, 5'd0, 0, 0, 5'd0, 4'd0);
  endtask

  // One clock: model predicts from current ID inputs, compare, clock, update model.
  task automatic tick(input string tag);
    int unsigned l, t, crs, crt;
    bit hz, es, ei;
    l   = (id_wr_lat == 0) ? 1 : ((id_wr_lat > 8) ? 8 : int'(id_wr_lat));
    t   = l + 2;
    crs = mcnt(id_rs);
    crt = mcnt(id_rt);
    hz  = (id_rs_used && id_rs != 0 && crs > 3) ||
          (id_rt_used && id_rt != 0 && crt > 3) ||
          (id_wr_en && id_wr_reg != 0 && mcnt(id_wr_reg) > t + 1) ||
          (id_wr_en && id_wr_reg != 0 && slot_busy(t + 1));
    es  = id_valid && !id_flush && hz;
    ei  = id_valid && !id_flush && !hz && !pipe_hold;
    #2;
    chk({tag, ".stall"}, stall, es);
    chk({tag, ".issue"}, issue, ei);
    if (ei) begin
      chk({tag, ".rs_sel"}, fwd_rs_sel, msel(crs));
      chk({tag, ".rt_sel"}, fwd_rt_sel, msel(crt));
    end
    @(posedge clk);
    #1;
    if (!pipe_hold) begin
      int unsigned keep [$];
      now++;
      foreach (wbq[i]) if (wbq[i] > now) keep.push_back(wbq[i]);
      wbq = keep;
      if (ei && id_wr_en && id_wr_reg != 0) begin
        eta[id_wr_reg] = now + t;
        wbq.push_back(now + t);
      end
    end
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick("drain");
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    rd_rs(5'd5, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.issue", issue, 0);
    chk("rst.rs_sel", fwd_rs_sel, 0);
    reset = 1'b0;
    #1;
    chk("post_rst.issue", issue, 1);
    chk("post_rst.rs_sel", fwd_rs_sel, 0);
    @(posedge clk);
    #1;
    drain(2);

    // ALU chain
    wr_op(5'd5, 4'd1); #1; chk("alu.prod_issue", issue, 1); tick("alu.prod");
    rd_rs(5'd5, 0); #1;
    chk("alu.stall", stall, 0); chk("alu.issue", issue, 1); chk("alu.sel", fwd_rs_sel, 1);
    tick("alu.cons");
    drain(4);

    // load-use
    wr_op(5'd8, 4'd2); tick("ld.prod");
    setid(1, 0, 0, 5'd0, 0, 5'd8, 1, 0, 5'd0, 4'd0);
    #1; chk("ld.stall1", stall, 1); chk("ld.issue1", issue, 0); tick("ld.c1");
    #1; chk("ld.stall2", stall, 0); chk("ld.sel", fwd_rt_sel, 1); tick("ld.c2");
    drain(4);

    // divider
    wr_op(5'd3, 4'd8); tick("div.prod");
    rd_rs(5'd3, 0);
    for (int i = 1; i <= 7; i++) begin
      #1; chk("div.stall", stall, 1); tick("div.wait");
    end
    #1; chk("div.stall_end", stall, 0); chk("div.issue", issue, 1); chk("div.sel", fwd_rs_sel, 1);
    tick("div.cons");
    drain(4);

    // structural: two write-backs in the same cycle
    wr_op(5'd3, 4'd4); tick("str.prod");
    idle(); tick("str.i1"); tick("str.i2");
    wr_op(5'd9, 4'd1);
    #1; chk("str.stall", stall, 1); tick("str.c1");
    #1; chk("str.stall_end", stall, 0); chk("str.issue", issue, 1); tick("str.c2");
    drain(12);

    // WAW: short producer behind a long one to the same register
    wr_op(5'd3, 4'd8); tick("waw.prod");
    wr_op(5'd3, 4'd1); #1; chk("waw.stall", stall, 1); tick("waw.c");
    drain(12);

    // flushed consumer never stalls
    wr_op(5'd3, 4'd8); tick("fl.prod");
    setid(1, 1, 0, 5'd3, 1, 5'd0, 0, 0, 5'd0, 4'd0);
    #1; chk("fl.stall", stall, 0); chk("fl.issue", issue, 0); tick("fl.c");
    drain(12);

    // register 0 is never tracked
    wr_op(5'd0, 4'd8); tick("r0.prod");
    rd_rs(5'd0, 0); #1; chk("r0.stall", stall, 0); chk("r0.sel", fwd_rs_sel, 0); tick("r0.c");
    drain(2);

    // latency clamping
    wr_op(5'd6, 4'd0); tick("lat0.prod");
    rd_rs(5'd6, 0); #1; chk("lat0.stall", stall, 0); chk("lat0.sel", fwd_rs_sel, 1); tick("lat0.c");
    wr_op(5'd7, 4'd15); tick("lat15.prod");
    rd_rs(5'd7, 0);
    for (int i = 1; i <= 7; i++) tick("lat15.wait");
    #1; chk("lat15.issue", issue, 1); chk("lat15.sel", fwd_rs_sel, 1); tick("lat15.c");
    drain(4);

    // pipe_hold during divider wait
    wr_op(5'd3, 4'd8); tick("hold.prod");
    for (int i = 1; i <= 10; i++) begin
      rd_rs(5'd3, (i >= 3 && i <= 5));
      #1; chk("hold.stall", stall, 1); tick("hold.wait");
    end
    rd_rs(5'd3, 0);
    #1; chk("hold.issue", issue, 1); chk("hold.sel", fwd_rs_sel, 1); tick("hold.c");
    drain(4);

    // reset in the middle of a divider wait
    wr_op(5'd3, 4'd8); tick("mrst.prod");
    rd_rs(5'd3, 0);
    repeat (3) tick("mrst.wait");
    #1; chk("mrst.pre", stall, 1);
    reset = 1'b1;
    #1; chk("mrst.stall", stall, 0); chk("mrst.issue", issue, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #1; chk("mrst.after_issue", issue, 1); chk("mrst.after_sel", fwd_rs_sel, 0);
    tick("mrst.c");
    drain(2);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      setid($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) < 70, 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
